// File: rtl/orao_ram_arbiter.sv
// orao_ram_arbiter: shares the ORAO single-port RAM between video fetch, 6502 CPU and serial loader.
// Build option ORAO_RAM_ARB_WBUF_EN adds a one-entry CPU write-posting buffer.
module orao_ram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_valid,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              starve
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        cnt_r;
    logic [7:0]        cnt_next_s;
    logic              starve_r;
    logic [1:0]        tag_r;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_hold_r;
    logic [DATA_W-1:0] wdata_s;
    logic              we_s;
    logic              vid_win_s;
    logic              cpu_win_s;
    logic              ldr_win_s;
    logic              drain_win_s;
    logic              cpu_cand_s;
    logic              drain_cand_s;
    logic              cpu_post_s;
    logic [ADDR_W-1:0] wb_addr_s;
    logic [DATA_W-1:0] wb_data_s;

`ifdef ORAO_RAM_ARB_WBUF_EN
    logic              wb_full_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;

    // Reads are held off while a posted write is pending so read-after-write stays coherent.
    assign cpu_cand_s   = cpu_req & ~cpu_we & ~wb_full_r;
    assign drain_cand_s = wb_full_r;
    assign cpu_post_s   = ~reset & cpu_req & cpu_we & ~wb_full_r;
    assign wb_addr_s    = wb_addr_r;
    assign wb_data_s    = wb_data_r;

    // Posting buffer: capture an accepted CPU write, release it once drained into RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_full_r <= 1'b0;
            wb_addr_r <= '0;
            wb_data_r <= '0;
        end else if (cpu_post_s) begin
            wb_full_r <= 1'b1;
            wb_addr_r <= cpu_addr;
            wb_data_r <= cpu_wdata;
        end else if (drain_win_s) begin
            wb_full_r <= 1'b0;
        end else begin
            wb_full_r <= wb_full_r;
        end
    end
`else
    assign cpu_cand_s   = cpu_req;
    assign drain_cand_s = 1'b0;
    assign cpu_post_s   = 1'b0;
    assign wb_addr_s    = '0;
    assign wb_data_s    = '0;
`endif

    // Grant selection: video always first; starvation lifts the loader above CPU and drain.
    always_comb begin
        vid_win_s   = 1'b0;
        cpu_win_s   = 1'b0;
        drain_win_s = 1'b0;
        ldr_win_s   = 1'b0;
        if (reset) begin
            vid_win_s = 1'b0;
        end else if (vid_req) begin
            vid_win_s = 1'b1;
        end else if (starve_r && ldr_req) begin
            ldr_win_s = 1'b1;
        end else if (cpu_cand_s) begin
            cpu_win_s = 1'b1;
        end else if (drain_cand_s) begin
            drain_win_s = 1'b1;
        end else if (ldr_req) begin
            ldr_win_s = 1'b1;
        end else begin
            ldr_win_s = 1'b0;
        end
    end

    // RAM port mux; with no winner the address and write data hold their last values.
    always_comb begin
        addr_s  = addr_hold_r;
        wdata_s = wdata_hold_r;
        we_s    = 1'b0;
        if (vid_win_s) begin
            addr_s = vid_addr;
        end else if (cpu_win_s) begin
            addr_s  = cpu_addr;
            we_s    = cpu_we;
            wdata_s = cpu_we ? cpu_wdata : wdata_hold_r;
        end else if (drain_win_s) begin
            addr_s  = wb_addr_s;
            we_s    = 1'b1;
            wdata_s = wb_data_s;
        end else if (ldr_win_s) begin
            addr_s  = ldr_addr;
            we_s    = 1'b1;
            wdata_s = ldr_wdata;
        end else begin
            we_s = 1'b0;
        end
    end

    // Loader starvation counter: saturating count of refused cycles, cleared on grant or idle.
    always_comb begin
        cnt_next_s = 8'd0;
        if (ldr_req && !ldr_win_s) begin
            cnt_next_s = (cnt_r == STARVE_LIM) ? cnt_r : cnt_r + 8'd1;
        end else begin
            cnt_next_s = 8'd0;
        end
    end

    // State registers: counter, starve flag, read-owner tag and held RAM payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= 8'd0;
            starve_r     <= 1'b0;
            tag_r        <= 2'b00;
            addr_hold_r  <= '0;
            wdata_hold_r <= '0;
        end else begin
            cnt_r        <= cnt_next_s;
            starve_r     <= (cnt_next_s == STARVE_LIM);
            tag_r        <= {vid_win_s, cpu_win_s & ~cpu_we};
            addr_hold_r  <= addr_s;
            wdata_hold_r <= wdata_s;
        end
    end

    assign vid_ack   = vid_win_s;
    assign cpu_ack   = cpu_win_s | cpu_post_s;
    assign ldr_ack   = ldr_win_s;
    assign vid_valid = tag_r[1] & ~reset;
    assign cpu_valid = tag_r[0] & ~reset;
    assign rdata     = ram_rdata;
    assign ram_addr  = addr_s;
    assign ram_we    = we_s;
    assign ram_wdata = wdata_s;
    assign starve    = starve_r;
endmodule

// File: doc/orao_ram_arbiter.md
# orao_ram_arbiter

Three-way arbiter that shares the ORAO single-port synchronous system/video RAM between the video scan-out fetcher, the 6502 CPU bus and the serial program loader. It runs in the CPU clock domain (25 MHz on the WXEDA build). It grants at most one RAM access per cycle, routes read data back to the owner, and bounds loader starvation.

## Interface
- ADDR_W, 13, RAM address width (8 KB window; 6 KB populated)
- DATA_W, 8, data width
- STARVE_MAX, 8, consecutive lost cycles after which the loader outranks the CPU; legal range 1..255

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- vid_req / vid_addr  in  1 / ADDR_W  video read request
- vid_ack  out  1  combinational grant
- vid_valid  out  1  read data valid
- cpu_req / cpu_we / cpu_addr / cpu_wdata  in  1 / 1 / ADDR_W / DATA_W  CPU access
- cpu_ack  out  1  combinational accept
- cpu_valid  out  1  read data valid
- ldr_req / ldr_addr / ldr_wdata  in  1 / ADDR_W / DATA_W  loader write (write-only)
- ldr_ack  out  1  combinational accept
- rdata  out  DATA_W  shared read-data return; equals ram_rdata
- ram_addr / ram_we / ram_wdata  out  ADDR_W / 1 / DATA_W  RAM port
- ram_rdata  in  DATA_W  RAM read data, one cycle after address
- starve  out  1  loader starvation override active

## Operation
- Handshake: requester holds req and payload stable until it sees ack high at a clock edge; the transfer completes in that cycle. Dropping req before ack is legal and cancels the request.
- Exactly one ack per cycle at most; ram_addr/ram_we/ram_wdata are the winner's payload, combinational mux. No winner: ram_we=0, ram_addr holds the previous value.
- Priority: video > CPU > loader. If starve=1, priority is video > loader > CPU. Video is never overridden.
- Starvation counter (8 bit): increments each cycle ldr_req=1 and ldr_ack=0, saturates at STARVE_MAX. It clears on ldr_ack or when ldr_req=0. starve = (count == STARVE_MAX), registered.
- Read return: a 2-bit owner tag registers {vid, cpu} read grants. In the cycle after a read grant, the matching *_valid pulses for one cycle with rdata = ram_rdata. Back-to-back reads from alternating owners are supported every cycle.
- Writes produce no valid pulse.

## Timing
- Reset values: all acks 0, vid_valid 0, cpu_valid 0, ram_we 0, ram_addr 0, ram_wdata 0, starve 0, counter 0, tag 0.
- Read latency: ack in cycle N, valid in N+1.
- Write latency: RAM written at the end of the ack cycle.
- Reset asserted mid-access: a pending valid is suppressed and the counter clears. An ack in the reset cycle is forced to 0.
- Simultaneous video and CPU request at the same address: video wins, and the CPU waits at least one cycle.
- The counter reaches STARVE_MAX at edge K. starve is high in cycle K+1, and the loader wins unless vid_req=1.

## Configuration
- ORAO_RAM_ARB_WBUF_EN:
  - Defined: adds a one-entry CPU write-posting buffer. A CPU write is acked immediately (same cycle as cpu_req) when the buffer is empty, regardless of other requesters.
    - The buffer drains at the lowest priority, but above the loader when starve=0, and whenever no video grant is issued.
    - CPU reads are not acked while the buffer is full, so read-after-write stays coherent.
    - A CPU write arriving while the buffer is full waits for the drain.
    - The buffer is cleared (content discarded) on reset.
  - Undefined: CPU writes arbitrate exactly like CPU reads.

## Test plan
- Reset, then all reqs idle -> every output at its reset value, ram_we=0 for 10 cycles.
- vid_req and cpu_req (read, 0x0100) both high in the same cycle, vid_addr=0x0200 -> vid_ack cycle 0, vid_valid with RAM[0x0200] in cycle 1; cpu_ack cycle 1, cpu_valid in cycle 2 with RAM[0x0100].
- ldr_req held with cpu_req continuous reads, STARVE_MAX=8 -> the loader is refused 8 cycles, starve goes high, and ldr_ack fires in the next cycle. After that cycle the counter is 0 and starve is 0.
- ldr_req held with vid_req continuous -> no ldr_ack, starve stays 1, and ram_we never asserts for the loader.
- Reset asserted the cycle after a CPU read grant -> cpu_valid stays 0 and all outputs return to reset values.
- With ORAO_RAM_ARB_WBUF_EN: CPU write 0x55 to 0x0010 during continuous video -> cpu_ack same cycle. A CPU read of 0x0010 is held off until the drain, then returns 0x55. Without the macro, the write ack is delayed until video releases.
